// File: rtl/ps2_keyboard_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard_pkg
//  Description : Shared constants and helpers for the PS/2 keyboard receiver.
//                Frame geometry, scan-code width, default FIFO depth, common
//                scan codes and the frame validity rule.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_keyboard_pkg;

    localparam int          PS2_FRAME_BITS = 11;
    localparam int          PS2_CODE_W     = 8;
    localparam int          FIFO_DEPTH     = 8;

    // Index of the stop bit within a frame (last sample).
    localparam logic [3:0]  PS2_STOP_IDX   = 4'(PS2_FRAME_BITS - 1);

    // Frequently used scan codes.
    localparam logic [7:0]  SC_A           = 8'h1C;
    localparam logic [7:0]  SC_BREAK       = 8'hF0;

    // A frame is good when the start bit is 0, the stop bit is 1 and the
    // eight data bits plus the parity bit hold an odd number of ones.
    function automatic logic ps2_frame_ok(input logic [9:0] frame,
                                          input logic       stop_bit);
        return ~frame[0] & stop_bit & (^frame[9:1]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx_fifo
//  Description : Synchronous scan-code FIFO. Pointers carry an extra wrap bit
//                so all DEPTH entries are usable. A push into a full FIFO is
//                accepted only when a pop happens in the same cycle.
//  Ports       : clk, rst        - clock, synchronous active-high reset
//                i_push, i_wdata - write request and data
//                i_pop           - read request (ignored while empty)
//                o_rdata         - head entry, zero while empty
//                o_empty, o_full - occupancy flags
//                o_drop          - push rejected because FIFO full
//                o_popped        - a pop took effect this cycle
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_empty,
    output logic             o_full,
    output logic             o_drop,
    output logic             o_popped
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;

    logic             w_empty;
    logic             w_full;
    logic             w_pop_en;
    logic             w_push_en;

    assign w_empty   = (r_wptr == r_rptr);
    assign w_full    = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) &&
                       (r_wptr[AW] != r_rptr[AW]);
    assign w_pop_en  = i_pop & ~w_empty;
    // When full, the slot being written is the head that is leaving this cycle.
    assign w_push_en = i_push & (~w_full | w_pop_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push_en) r_wptr <= r_wptr + 1'b1;
            if (w_pop_en)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push_en) r_mem[r_wptr[AW-1:0]] <= i_wdata;
    end

    assign o_rdata  = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
    assign o_empty  = w_empty;
    assign o_full   = w_full;
    assign o_drop   = i_push & ~w_push_en;
    assign o_popped = w_pop_en;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_keyboard
//  Description : PS/2 device-to-host receiver. Oversamples ps2_clk/ps2_data,
//                deserialises 11-bit frames on falling ps2_clk edges, checks
//                start/parity/stop and queues good scan codes in a FIFO.
//  Ports       : clk        - system clock
//                clrn       - synchronous reset, active HIGH despite the name
//                ps2_clk    - raw PS/2 clock (asynchronous)
//                ps2_data   - raw PS/2 data (asynchronous)
//                nextdata_n - active-low pop request
//                data       - scan code at FIFO head, 8'h00 when empty
//                ready      - FIFO non-empty
//                overflow   - sticky: a good frame was lost to a full FIFO
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_keyboard
    import ps2_keyboard_pkg::*;
#(
    parameter int FIFO_DEPTH = ps2_keyboard_pkg::FIFO_DEPTH
) (
    input  logic                  clk,
    input  logic                  clrn,
    input  logic                  ps2_clk,
    input  logic                  ps2_data,
    input  logic                  nextdata_n,
    output logic [PS2_CODE_W-1:0] data,
    output logic                  ready,
    output logic                  overflow
);
    // Synchronisers: [0] is stage 1. Data stages line up with clock stages 1-2.
    logic [2:0] r_clk_sync;
    logic [1:0] r_dat_sync;
    logic [3:0] r_cnt;
    logic [9:0] r_frame;
    logic       r_overflow;

    logic       w_fall;
    logic       w_sample;
    logic       w_push;
    logic       w_empty;
    logic       w_full;
    logic       w_drop;
    logic       w_popped;

    assign w_fall   = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_sample = r_dat_sync[1];
    assign w_push   = w_fall && (r_cnt == PS2_STOP_IDX) &&
                      ps2_frame_ok(r_frame, w_sample);

    always_ff @(posedge clk) begin
        if (clrn) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
            r_cnt      <= '0;
            r_frame    <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], ps2_clk};
            r_dat_sync <= {r_dat_sync[0], ps2_data};

            if (w_fall) begin
                // Counter restarts after the stop bit whether or not the
                // frame was good; bad frames are simply not pushed.
                if (r_cnt == PS2_STOP_IDX) begin
                    r_cnt <= '0;
                end else begin
                    r_frame[r_cnt] <= w_sample;
                    r_cnt          <= r_cnt + 4'd1;
                end
            end

            // Drop and pop cannot coincide: a pop makes room for the push.
            if (w_drop)        r_overflow <= 1'b1;
            else if (w_popped) r_overflow <= 1'b0;
        end
    end

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PS2_CODE_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (clrn),
        .i_push   (w_push),
        .i_wdata  (r_frame[8:1]),
        .i_pop    (~nextdata_n),
        .o_rdata  (data),
        .o_empty  (w_empty),
        .o_full   (w_full),
        .o_drop   (w_drop),
        .o_popped (w_popped)
    );

    assign ready    = ~w_empty;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_keyboard
//  Description : Self-checking bench for ps2_keyboard. Frames are built from
//                bytes plus optional corruptions; a queue model decides which
//                codes should be held, and outputs are compared to it.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_keyboard;
    import ps2_keyboard_pkg::*;

    // System clocks per half PS/2 bit: 4 high / 8 low / 4 high.
    localparam int H = 8;

    logic       clk        = 1'b0;
    logic       clrn       = 1'b1;
    logic       ps2_clk    = 1'b1;
    logic       ps2_data   = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;

    always #10 clk = ~clk;

    ps2_keyboard #(.FIFO_DEPTH(8)) dut (
        .clk        (clk),
        .clrn       (clrn),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .nextdata_n (nextdata_n),
        .data       (data),
        .ready      (ready),
        .overflow   (overflow)
    );

    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check_val({tag, "_ready"},    32'(ready),    32'(q.size() != 0));
        check_val({tag, "_data"},     32'(data),     32'(q.size() != 0 ? q[0] : 8'h00));
        check_val({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    endtask

    // One PS/2 bit. pop_here pulses nextdata_n so the pop lands on the same
    // clk edge as a push caused by this falling edge (2 sync stages + 1).
    task automatic send_bit(input logic b, input bit pop_here, input bit lat_chk);
        ps2_data = b;
        repeat (H/2) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 1; i <= H; i++) begin
            @(negedge clk);
            if (i == 2) begin
                if (lat_chk) check_val("latency_before", 32'(ready), 32'd0);
                if (pop_here) begin
                    if (q.size() != 0) check_val("pop_at_stop_data", 32'(data), 32'(q[0]));
                    nextdata_n = 1'b0;
                end
            end
            if (i == 3) begin
                if (lat_chk) check_val("latency_after", 32'(ready), 32'd1);
                nextdata_n = 1'b1;
            end
        end
        ps2_clk = 1'b1;
        repeat (H/2) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_start,
                              input bit bad_par, input bit bad_stop,
                              input bit pop_at_stop, input bit lat_chk);
        logic [10:0] bits;
        logic        par;
        par  = (~^d) ^ bad_par;
        bits = {~bad_stop, par, d, bad_start};
        for (int i = 0; i < 11; i++)
            send_bit(bits[i], (i == 10) && pop_at_stop, (i == 10) && lat_chk);
        // Model: a pop on the push cycle frees space first.
        if (pop_at_stop && q.size() != 0) begin
            void'(q.pop_front());
            m_ovf = 1'b0;
        end
        if (!bits[0] && bits[10] && (^bits[9:1])) begin
            if (q.size() < 8) q.push_back(d);
            else              m_ovf = 1'b1;
        end
        check_state("frame");
    endtask

    task automatic pop_one();
        if (q.size() != 0) check_val("pop_head", 32'(data), 32'(q[0]));
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        if (q.size() != 0) begin
            void'(q.pop_front());
            m_ovf = 1'b0;
        end
        check_state("pop");
    endtask

    task automatic do_reset();
        clrn = 1'b1;
        q.delete();
        m_ovf = 1'b0;
        repeat (3) @(negedge clk);
        check_state("in_reset");
        clrn = 1'b0;
        @(negedge clk);
        check_state("after_reset");
    endtask

    initial begin
        logic [10:0] partial;
        int          r;

        // Reset state
        do_reset();

        // 1: single 0x1C with latency check, then pop
        send_frame(SC_A, 0, 0, 0, 0, 1);
        pop_one();

        // 2: back-to-back make/break/make
        send_frame(SC_A, 0, 0, 0, 0, 0);
        send_frame(SC_BREAK, 0, 0, 0, 0, 0);
        send_frame(SC_A, 0, 0, 0, 0, 0);
        repeat (3) pop_one();

        // 3: bad parity, bad stop, then a good frame
        send_frame(SC_A, 0, 1, 0, 0, 0);
        send_frame(SC_A, 0, 0, 1, 0, 0);
        send_frame(8'h32, 0, 0, 0, 0, 0);
        pop_one();

        // 4: overflow on the ninth frame
        for (int k = 1; k <= 9; k++) send_frame(8'(k), 0, 0, 0, 0, 0);
        check_val("ovf_set", 32'(overflow), 32'd1);
        repeat (8) pop_one();

        // 5: push coinciding with pop at full occupancy
        for (int k = 0; k < 8; k++) send_frame(8'(8'h40 + k), 0, 0, 0, 0, 0);
        send_frame(8'h55, 0, 0, 0, 1, 0);
        check_val("full_pop_push_ovf", 32'(overflow), 32'd0);
        repeat (8) pop_one();

        // 6: reset in the middle of a frame
        partial = {1'b1, ~^8'hA7, 8'hA7, 1'b0};
        for (int i = 0; i < 5; i++) send_bit(partial[i], 0, 0);
        do_reset();
        send_frame(SC_A, 0, 0, 0, 0, 0);
        pop_one();

        // Randomised traffic with occasional corruption and coincident pops
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 15);
            send_frame(8'($urandom), r == 0, r == 1, r == 2,
                       $urandom_range(0, 3) == 0, 0);
            repeat ($urandom_range(0, 2)) pop_one();
        end
        while (q.size() != 0) pop_one();
        pop_one();  // pop while empty has no effect

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- PS/2 device-to-host receiver.
- Oversamples the asynchronous ps2_clk/ps2_data lines with the system clock.
- Deserialises 11-bit frames, validates them, and queues the 8-bit scan codes in a small FIFO.
- A consumer (top-level key handler) pops codes through a ready/nextdata_n handshake; FIFO overrun is reported on overflow.

Parameters:
- FIFO_DEPTH, 8: scan-code FIFO entries; must be a power of two; all 8 entries usable.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clrn  in  1  synchronous, active-high reset, despite the name.
- ps2_clk  in  1  raw PS/2 clock line, asynchronous.
- ps2_data  in  1  raw PS/2 data line, asynchronous.
- nextdata_n  in  1  active-low pop request; one code consumed per clk cycle it is low while ready=1.
- data  out  8  scan code at FIFO head; 8'h00 when FIFO empty.
- ready  out  1  FIFO non-empty.
- overflow  out  1  frame lost because FIFO was full.

Behaviour:
- Reset (clrn=1 at posedge clk):
  - bit counter=0, shift buffer=0, read/write pointers=0, FIFO occupancy=0.
  - Synchronisers set to all-ones (idle line).
  - Outputs: ready=0, overflow=0, data=8'h00.
  - Reset wins over every other event in the same cycle.
- Synchronisation:
  - ps2_clk passes through a 3-flop shift register.
  - ps2_data passes through 2 flops, aligned with ps2_clk stages 1-2.
  - Falling edge = stage3 & ~stage2; it is a one-cycle pulse.
  - ps2_data (sync stage 2 output) is sampled in the pulse cycle.
- Frame: 11 bits, LSB first: start(0), d0..d7, odd parity, stop(1).
  - The 4-bit counter 0..10 indexes the sample.
  - Samples 0..9 are written into a 10-bit buffer at the counter index, and the counter increments.
  - On sample 10 (stop), the frame is valid iff buffer[0]==0, stop==1, and XOR(buffer[9:1])==1 (odd parity).
  - Counter returns to 0 after sample 10 regardless of validity.
  - Invalid frames are silently discarded: no FIFO write, no flag.
  - No inter-frame timeout; a glitch desynchronises the counter until framing checks reject frames.
- Push: a valid frame writes buffer[8:1] to FIFO[wptr] and increments wptr (wrap modulo FIFO_DEPTH).
  - ready rises the cycle after the stop-bit edge pulse.
- Pop: in each cycle with nextdata_n==0 and ready==1, rptr increments and occupancy decrements.
  - data changes to the next entry in the following cycle.
  - nextdata_n==0 while empty has no effect.
- data is driven combinationally from FIFO[rptr] when non-empty.
- Full (occupancy==FIFO_DEPTH):
  - A valid frame arriving with no pop in the same cycle is dropped; FIFO contents are untouched and overflow is set to 1.
  - With a pop in the same cycle, the push is accepted and no overflow is flagged.
- Simultaneous push and pop at any other occupancy: both take effect, occupancy unchanged.
- overflow is sticky; it clears to 0 on the next successful pop, or on reset.
- Occupancy uses a log2(FIFO_DEPTH)+1-bit counter, or pointers with an extra wrap bit.
  - ready = (occupancy!=0); full = (occupancy==FIFO_DEPTH).

Decomposition:
- Shared package:
  - PS2_FRAME_BITS=11.
  - PS2_CODE_W=8.
  - FIFO_DEPTH default.
  - Scan-code constants used by benches (8'h1C 'A', 8'hF0 break prefix).
- One natural sub-module: ps2_rx_fifo.
  - Synchronous FIFO with push, pop, data, empty and full.
  - The frame receiver and synchroniser stay in ps2_keyboard.

Test Plan:
1. Reset, then one frame of 0x1C (bits 0,0,0,1,1,1,0,0,0,parity 0,stop 1), PS/2 clock ~10 kHz, clk 50 MHz -> ready=1 one cycle after stop edge, data=8'h1C, overflow=0; one-cycle nextdata_n=0 -> ready=0, data=8'h00.
2. Back-to-back 0x1C, 0xF0, 0x1C without popping -> ready stays 1; successive single-cycle pops yield 1C, F0, 1C, then ready=0.
3. Frame 0x1C with parity bit 1 -> ready stays 0, no write. Separately, frame with stop bit 0 -> no write. A following good 0x32 frame is received correctly.
4. 9 valid frames 0x01..0x09 without popping -> after the 9th, overflow=1 and FIFO holds 0x01..0x08. First pop returns 0x01 and clears overflow; 0x09 is never returned.
5. Push completing in the same cycle as a pop at occupancy 8 -> no overflow, occupancy stays 8, ordering preserved.
6. Assert clrn mid-frame (after 5 bits), release, send 0x1C -> only 0x1C received; ready/overflow/data are 0 during and right after reset.
